serial_core_scheduler: RTL

Round-robin scheduler that shares one bit-serial Mealy detector core (1-bit x in, 1-bit y out, async active-low clear) among NREQ requesters. Each granted requester supplies a WIDTH-bit word. The scheduler clears the core, streams the word into it LSB first, and captures the core's per-bit y responses into a WIDTH-bit result tagged with the requester ID. It sits between the requesting datapaths and the single shared core instance.

---
 rtl/serial_core_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/serial_core_scheduler.sv
// ---------------------------------------------------------------------------
// serial_core_scheduler
//
// Round-robin scheduler sharing one bit-serial Mealy detector core among NREQ
// requesters. A granted requester's WIDTH-bit word is latched, the core is
// cleared for one cycle, then the word is streamed LSB first on core_x while
// the core's per-bit core_y responses are collected into result (bit i is the
// response to input bit i), tagged with the requester ID.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   req          per-requester level request
//   data_in      word of requester i at [i*WIDTH +: WIDTH], sampled on grant
//   gnt          one-hot one-cycle grant pulse (word captured)
//   busy         high in every state except IDLE
//   core_x       serial bit to the shared core
//   core_rst_n   registered active-low clear to the shared core
//   core_y       core Mealy output for the current core_x
//   result       captured response word
//   result_id    requester that owns result
//   result_valid one-cycle result strobe
// ---------------------------------------------------------------------------
module serial_core_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data_in,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    core_x,
    output logic                    core_rst_n,
    input  logic                    core_y,
    output logic [WIDTH-1:0]        result,
    output logic [ID_W-1:0]         result_id,
    output logic                    result_valid
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    state_t           state;
    logic [ID_W-1:0]  last_id;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;

    // Arbitration result, meaningful only in IDLE
    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic [NREQ-1:0]  win_onehot;
    logic [WIDTH-1:0] win_word;
    logic [ID_W:0]    cand;

    // Search last_id+1, last_id+2, ... modulo NREQ. The candidate index is
    // compared against each constant requester number so every select into
    // req/data_in stays constant.
    always_comb begin
        win_found  = 1'b0;
        win_id     = '0;
        win_onehot = '0;
        win_word   = '0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_id} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NREQ))
                cand = cand - (ID_W+1)'(NREQ);
            for (int i = 0; i < NREQ; i++) begin
                if (!win_found && req[i] && (cand == (ID_W+1)'(i))) begin
                    win_found     = 1'b1;
                    win_id        = ID_W'(i);
                    win_onehot[i] = 1'b1;
                    win_word      = data_in[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Control FSM and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_id      <= ID_W'(NREQ-1);
            cnt          <= '0;
            gnt          <= '0;
            busy         <= 1'b0;
            core_x       <= 1'b0;
            core_rst_n   <= 1'b0;
            result       <= '0;
            result_id    <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    result_valid <= 1'b0;
                    if (win_found) begin
                        last_id    <= win_id;
                        result_id  <= win_id;
                        gnt        <= win_onehot;
                        core_rst_n <= 1'b0;
                        busy       <= 1'b1;
                        state      <= CLEAR;
                    end else begin
                        // Releases the core clear on the first edge after reset
                        core_rst_n <= 1'b1;
                    end
                end
                CLEAR: begin
                    gnt        <= '0;
                    core_rst_n <= 1'b1;
                    core_x     <= shreg[0];
                    cnt        <= '0;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    // core_y answers the bit currently on core_x
                    result <= {core_y, result[WIDTH-1:1]};
                    core_x <= shreg[0];
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH-1)) begin
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word shift register: pure datapath, no reset needed. It is loaded on the
    // grant edge and shifted so shreg[0] always holds the next bit to send.
    always_ff @(posedge clock) begin
        if (state == IDLE && win_found)
            shreg <= win_word;
        else if (state == CLEAR || state == SHIFT)
            shreg <= shreg >> 1;
    end

endmodule
